rgb_stream_packer: RTL and testbench

- Downstream neighbour of the ray tracing unit inside the pixel generator.
- Accepts one 24-bit RGB pixel per beat with SOF/EOL sideband and packs every 4 pixels into 3 32-bit AXI4-Stream words for the VDMA.
- Owns line alignment: flushes partial groups on early EOL, resyncs on misplaced SOF, and flags both.
- Registered 2-entry output skid buffer so the upstream ready depends on flops only.

---
 rtl/rt_stream_pkg.sv | 36 +++
 rtl/axis_skid2.sv | 50 +++++
 rtl/rgb_stream_packer.sv | 153 +++++++++++++++
 tb/tb_rgb_stream_packer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_stream_pkg.sv
// Shared types and constants for the RGB-to-AXI4-Stream packing path.
// Four 24-bit pixels pack into three 32-bit words.
package rt_stream_pkg;

  localparam int PIX_PER_GROUP   = 4;
  localparam int WORDS_PER_GROUP = 3;
  localparam int PHASE_W         = $clog2(PIX_PER_GROUP);

  typedef logic [23:0] rgb_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        user;
  } axis_word_t;

  typedef enum logic {
    PACK  = 1'b0,
    FLUSH = 1'b1
  } packer_state_t;

  // Phase here is the post-advance phase (1..3); the residual holds
  // whatever bytes of the group were not yet emitted.
  function automatic logic [31:0] pad_word(input logic [PHASE_W-1:0] phase,
                                           input rgb_t                res,
                                           input logic [7:0]          pad);
    logic [31:0] w;
    unique case (phase)
      2'd2:    w = {pad, pad, res[15:0]};
      2'd3:    w = {pad, pad, pad, res[7:0]};
      default: w = {pad, res};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/axis_skid2.sv
// Two-entry register buffer; entry 0 is the head and drives the stream outputs.
// Push and pop may coincide; the caller never pushes into a full buffer.
module axis_skid2
  import rt_stream_pkg::*;
(
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       push,
  input  axis_word_t push_word,
  input  logic       pop,
  output axis_word_t head,
  output logic [1:0] count
);

  axis_word_t ent0;
  axis_word_t ent1;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) ent0 <= push_word;
          else               ent1 <= push_word;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Head leaves while the new word lands behind whatever remains.
          if (count == 2'd1) begin
            ent0 <= push_word;
          end else begin
            ent0 <= ent1;
            ent1 <= push_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = ent0;

endmodule

// File: rtl/rgb_stream_packer.sv
// Packs 24-bit RGB pixels four-at-a-time into three 32-bit AXI4-Stream words,
// handling early EOL (padded flush) and misplaced SOF (resync), both flagged.
module rgb_stream_packer
  import rt_stream_pkg::*;
#(
  parameter int         SKID_DEPTH = 2,
  parameter logic [7:0] PAD_BYTE   = 8'h00
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        valid,
  input  logic        sof,
  input  logic        eol,
  output logic        in_stream_ready,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  output logic        out_stream_tuser,
  output logic        out_stream_tvalid,
  input  logic        out_stream_tready,
  output logic        err_align
);

  localparam logic [1:0] FULL_COUNT = 2'(SKID_DEPTH);

  packer_state_t      state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  rgb_t               residual_q, residual_d;
  logic               pending_sof_q, pending_sof_d;
  logic               err_q, err_d;

  logic               accept;
  logic               push;
  axis_word_t         push_word;
  logic               pop;
  axis_word_t         head;
  logic [1:0]         count;
  logic [PHASE_W-1:0] eff_phase;
  logic               pend;
  rgb_t               pix;

  assign pix = {r, g, b};

  // Ready depends only on registered state so upstream sees no comb path.
  assign in_stream_ready = (state_q == PACK) &&
                           ((count < FULL_COUNT) || (phase_q == '0));
  assign accept = valid && in_stream_ready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= PACK;
      phase_q       <= '0;
      residual_q    <= '0;
      pending_sof_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      residual_q    <= residual_d;
      pending_sof_q <= pending_sof_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    residual_d    = residual_q;
    pending_sof_d = pending_sof_q;
    err_d         = err_q;
    push          = 1'b0;
    push_word     = '0;
    // A SOF pixel always restarts the group as P0, dropping any residual.
    eff_phase     = sof ? '0 : phase_q;
    pend          = pending_sof_q | sof;

    unique case (state_q)
      PACK: begin
        if (accept) begin
          if (sof && (phase_q != '0)) err_d = 1'b1;
          unique case (eff_phase)
            2'd0: begin
              residual_d = pix;
            end
            2'd1: begin
              push           = 1'b1;
              push_word.data = {pix[7:0], residual_q};
              residual_d     = {8'h00, pix[23:8]};
            end
            2'd2: begin
              push           = 1'b1;
              push_word.data = {pix[15:0], residual_q[15:0]};
              residual_d     = {16'h0000, pix[23:16]};
            end
            default: begin
              push           = 1'b1;
              push_word.data = {pix, residual_q[7:0]};
              push_word.last = eol;
            end
          endcase
          // The 2-bit phase wraps 3->0 on its own; a mid-group EOL keeps
          // the advanced phase so FLUSH knows how many bytes remain.
          phase_d = eff_phase + 1'b1;
          if (eol && (eff_phase != 2'd3)) begin
            state_d = FLUSH;
            err_d   = 1'b1;
          end
          if (push) begin
            push_word.user = pend;
            pending_sof_d  = 1'b0;
          end else begin
            pending_sof_d  = pend;
          end
        end
      end
      FLUSH: begin
        if (count < FULL_COUNT) begin
          push           = 1'b1;
          push_word.data = pad_word(phase_q, residual_q, PAD_BYTE);
          push_word.last = 1'b1;
          push_word.user = pending_sof_q;
          pending_sof_d  = 1'b0;
          state_d        = PACK;
          phase_d        = '0;
        end
      end
      default: state_d = PACK;
    endcase
  end

  assign pop = out_stream_tvalid && out_stream_tready;

  axis_skid2 u_skid (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (push),
    .push_word (push_word),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign out_stream_tvalid = (count != 2'd0);
  assign out_stream_tdata  = head.data;
  assign out_stream_tlast  = head.last;
  assign out_stream_tuser  = head.user;
  assign out_stream_tkeep  = 4'hF;
  assign err_align         = err_q;

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Directed bench for rgb_stream_packer: observed words are captured by a
// monitor and compared against hand-computed expected words per scenario.
module tb_rgb_stream_packer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [7:0]  r, g, b;
  logic        valid, sof, eol;
  logic        in_stream_ready;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast;
  logic        out_stream_tuser;
  logic        out_stream_tvalid;
  logic        out_stream_tready;
  logic        err_align;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int tr_mode = 0;
  int stall_viol = 0;
  int ready_low_cnt = 0;

  logic [33:0] exp_q[$];
  logic [33:0] obs_q[$];
  logic        prev_stall = 1'b0;
  logic [33:0] prev_word = '0;

  always #5 aclk = ~aclk;

  rgb_stream_packer #(.SKID_DEPTH(2), .PAD_BYTE(8'h00)) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .r                 (r),
    .g                 (g),
    .b                 (b),
    .valid             (valid),
    .sof               (sof),
    .eol               (eol),
    .in_stream_ready   (in_stream_ready),
    .out_stream_tdata  (out_stream_tdata),
    .out_stream_tkeep  (out_stream_tkeep),
    .out_stream_tlast  (out_stream_tlast),
    .out_stream_tuser  (out_stream_tuser),
    .out_stream_tvalid (out_stream_tvalid),
    .out_stream_tready (out_stream_tready),
    .err_align         (err_align)
  );

  always @(posedge aclk) cyc <= cyc + 1;

  // tready: 0 = always high, 1 = repeating 1,0,0,1, 2 = held low
  initial begin
    out_stream_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (tr_mode)
        1:       out_stream_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2:       out_stream_tready = 1'b0;
        default: out_stream_tready = 1'b1;
      endcase
    end
  end

  // Monitor: record accepted words, stall-hold violations and ready drops.
  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (out_stream_tvalid !== 1'b1 ||
          {out_stream_tuser, out_stream_tlast, out_stream_tdata} !== prev_word))
        stall_viol++;
      if (out_stream_tvalid && out_stream_tready)
        obs_q.push_back({out_stream_tuser, out_stream_tlast, out_stream_tdata});
      if (valid && !in_stream_ready) ready_low_cnt++;
      prev_stall = out_stream_tvalid && !out_stream_tready;
      prev_word  = {out_stream_tuser, out_stream_tlast, out_stream_tdata};
    end
  end

  task automatic do_reset();
    aresetn = 1'b0;
    valid = 1'b0; sof = 1'b0; eol = 1'b0;
    r = 8'h00; g = 8'h00; b = 8'h00;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    obs_q.delete();
    exp_q.delete();
    stall_viol = 0;
    ready_low_cnt = 0;
  endtask

  task automatic send_pix(input logic [23:0] p, input logic s, input logic e);
    int t;
    bit done;
    {r, g, b} = p;
    sof = s; eol = e; valid = 1'b1;
    done = 0; t = 0;
    while (!done && t < 200) begin
      @(negedge aclk);
      done = in_stream_ready;
      @(posedge aclk);
      #1;
      t++;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL send_timeout: pixel %h not accepted in %0d cycles", p, t);
    end
    valid = 1'b0; sof = 1'b0; eol = 1'b0;
  endtask

  task automatic wait_drain(input int n);
    int t;
    t = 0;
    while (obs_q.size() < n && t < 500) begin
      @(posedge aclk);
      t++;
    end
    repeat (6) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    valid = 1'b0; sof = 1'b0; eol = 1'b0;
    {r, g, b} = 24'h0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    n_checks++; if (out_stream_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", out_stream_tvalid); else n_pass++;
    n_checks++; if (out_stream_tdata !== 32'h0) $display("FAIL rst_tdata: got %h want 00000000", out_stream_tdata); else n_pass++;
    n_checks++; if (out_stream_tlast !== 1'b0) $display("FAIL rst_tlast: got %b want 0", out_stream_tlast); else n_pass++;
    n_checks++; if (out_stream_tuser !== 1'b0) $display("FAIL rst_tuser: got %b want 0", out_stream_tuser); else n_pass++;
    n_checks++; if (err_align !== 1'b0) $display("FAIL rst_err: got %b want 0", err_align); else n_pass++;
    n_checks++; if (out_stream_tkeep !== 4'hF) $display("FAIL rst_tkeep: got %h want F", out_stream_tkeep); else n_pass++;
    n_checks++; if (in_stream_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", in_stream_ready); else n_pass++;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic send_frame8();
    send_pix(24'h010203, 1'b1, 1'b0);
    send_pix(24'h040506, 1'b0, 1'b0);
    send_pix(24'h070809, 1'b0, 1'b0);
    send_pix(24'h0A0B0C, 1'b0, 1'b0);
    send_pix(24'h0D0E0F, 1'b0, 1'b0);
    send_pix(24'h101112, 1'b0, 1'b0);
    send_pix(24'h131415, 1'b0, 1'b0);
    send_pix(24'h161718, 1'b0, 1'b1);
  endtask

  task automatic load_frame8_exp();
    exp_q.push_back({1'b1, 1'b0, 32'h06010203});
    exp_q.push_back({1'b0, 1'b0, 32'h08090405});
    exp_q.push_back({1'b0, 1'b0, 32'h0A0B0C07});
    exp_q.push_back({1'b0, 1'b0, 32'h120D0E0F});
    exp_q.push_back({1'b0, 1'b0, 32'h14151011});
    exp_q.push_back({1'b0, 1'b1, 32'h16171813});
  endtask

  task automatic test_basic();
    do_reset();
    tr_mode = 0;
    load_frame8_exp();
    send_frame8();
    wait_drain(6);
    n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL basic_word%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 34'bx, exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (err_align !== 1'b0) $display("FAIL basic_err: got %b want 0", err_align); else n_pass++;
    n_checks++; if (ready_low_cnt !== 0) $display("FAIL basic_ready_low: got %0d want 0", ready_low_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back_stall();
    do_reset();
    tr_mode = 1;
    load_frame8_exp();
    send_frame8();
    wait_drain(6);
    tr_mode = 0;
    n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL stall_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL stall_word%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 34'bx, exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (stall_viol !== 0) $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_viol); else n_pass++;
    n_checks++; if (ready_low_cnt == 0) $display("FAIL stall_ready_drop: got %0d low cycles want >0", ready_low_cnt); else n_pass++;
  endtask

  task automatic test_early_eol();
    // EOL on the second pixel
    do_reset();
    tr_mode = 0;
    exp_q.push_back({1'b0, 1'b0, 32'h33AABBCC});
    exp_q.push_back({1'b0, 1'b1, 32'h00001122});
    send_pix(24'hAABBCC, 1'b0, 1'b0);
    send_pix(24'h112233, 1'b0, 1'b1);
    @(negedge aclk);
    n_checks++; if (in_stream_ready !== 1'b0) $display("FAIL eol1_flush_ready: got %b want 0", in_stream_ready); else n_pass++;
    @(negedge aclk);
    n_checks++; if (in_stream_ready !== 1'b1) $display("FAIL eol1_ready_back: got %b want 1", in_stream_ready); else n_pass++;
    wait_drain(2);
    n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL eol1_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL eol1_word%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 34'bx, exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (err_align !== 1'b1) $display("FAIL eol1_err: got %b want 1", err_align); else n_pass++;

    // EOL on the third pixel
    do_reset();
    exp_q.push_back({1'b0, 1'b0, 32'h33AABBCC});
    exp_q.push_back({1'b0, 1'b0, 32'h55661122});
    exp_q.push_back({1'b0, 1'b1, 32'h00000044});
    send_pix(24'hAABBCC, 1'b0, 1'b0);
    send_pix(24'h112233, 1'b0, 1'b0);
    send_pix(24'h445566, 1'b0, 1'b1);
    wait_drain(3);
    n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL eol2_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL eol2_word%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 34'bx, exp_q[i]);
      else n_pass++;
    end

    // SOF and EOL on one pixel at phase 0
    do_reset();
    exp_q.push_back({1'b1, 1'b1, 32'h00778899});
    send_pix(24'h778899, 1'b1, 1'b1);
    wait_drain(1);
    n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL soleol_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL soleol_word%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 34'bx, exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (err_align !== 1'b1) $display("FAIL soleol_err: got %b want 1", err_align); else n_pass++;
  endtask

  task automatic test_misplaced_sof();
    do_reset();
    tr_mode = 0;
    exp_q.push_back({1'b0, 1'b0, 32'h22111111});
    exp_q.push_back({1'b1, 1'b0, 32'h44332211});
    exp_q.push_back({1'b0, 1'b0, 32'h88776655});
    exp_q.push_back({1'b0, 1'b1, 32'hCCBBAA99});
    send_pix(24'h111111, 1'b0, 1'b0);
    send_pix(24'h222222, 1'b0, 1'b0);
    @(negedge aclk);
    n_checks++; if (err_align !== 1'b0) $display("FAIL sof_err_before: got %b want 0", err_align); else n_pass++;
    @(posedge aclk);
    #1;
    send_pix(24'h332211, 1'b1, 1'b0);
    send_pix(24'h665544, 1'b0, 1'b0);
    send_pix(24'h998877, 1'b0, 1'b0);
    send_pix(24'hCCBBAA, 1'b0, 1'b1);
    wait_drain(4);
    n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL sof_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL sof_word%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 34'bx, exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (err_align !== 1'b1) $display("FAIL sof_err: got %b want 1", err_align); else n_pass++;
  endtask

  task automatic test_reset_mid_group();
    do_reset();
    tr_mode = 2;
    repeat (2) @(posedge aclk);
    #1;
    send_pix(24'hAABBCC, 1'b0, 1'b0);
    send_pix(24'h112233, 1'b0, 1'b0);
    @(negedge aclk);
    n_checks++; if (out_stream_tvalid !== 1'b1) $display("FAIL midrst_pending: got %b want 1", out_stream_tvalid); else n_pass++;
    @(posedge aclk);
    #1;
    do_reset();
    @(negedge aclk);
    n_checks++; if (out_stream_tvalid !== 1'b0) $display("FAIL midrst_flushed: got %b want 0", out_stream_tvalid); else n_pass++;
    @(posedge aclk);
    #1;
    tr_mode = 0;
    exp_q.push_back({1'b0, 1'b0, 32'h06010203});
    exp_q.push_back({1'b0, 1'b0, 32'h08090405});
    exp_q.push_back({1'b0, 1'b1, 32'h0A0B0C07});
    send_pix(24'h010203, 1'b0, 1'b0);
    send_pix(24'h040506, 1'b0, 1'b0);
    send_pix(24'h070809, 1'b0, 1'b0);
    send_pix(24'h0A0B0C, 1'b0, 1'b1);
    wait_drain(3);
    n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL midrst_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL midrst_word%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 34'bx, exp_q[i]);
      else n_pass++;
    end
  endtask

  function automatic logic [23:0] line_pix(input int i);
    logic [15:0] t;
    t = 16'(i);
    return {t[7:0] ^ 8'h5A, t[15:8] ^ 8'hC3, t[7:0]};
  endfunction

  task automatic test_long_line();
    logic [95:0] grp;
    int c0, n_last;
    do_reset();
    tr_mode = 0;
    for (int gi = 0; gi < 160; gi++) begin
      grp = {line_pix(4*gi+3), line_pix(4*gi+2), line_pix(4*gi+1), line_pix(4*gi)};
      for (int k = 0; k < 3; k++)
        exp_q.push_back({1'b0, (gi == 159 && k == 2), grp[32*k +: 32]});
    end
    c0 = cyc;
    for (int i = 0; i < 640; i++) send_pix(line_pix(i), 1'b0, (i == 639));
    n_checks++; if (cyc - c0 !== 640) $display("FAIL line_cycles: got %0d want 640", cyc - c0); else n_pass++;
    wait_drain(480);
    n_checks++; if (obs_q.size() !== 480) $display("FAIL line_count: got %0d want 480", obs_q.size()); else n_pass++;
    n_last = 0;
    foreach (obs_q[i]) if (obs_q[i][32]) n_last++;
    n_checks++; if (n_last !== 1) $display("FAIL line_tlast_count: got %0d want 1", n_last); else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL line_word%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 34'bx, exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (err_align !== 1'b0) $display("FAIL line_err: got %b want 0", err_align); else n_pass++;
  endtask

  initial begin
    aresetn = 1'b0;
    valid = 1'b0; sof = 1'b0; eol = 1'b0;
    r = 8'h00; g = 8'h00; b = 8'h00;
    test_reset();
    test_basic();
    test_back_to_back_stall();
    test_early_eol();
    test_misplaced_sof();
    test_reset_mid_group();
    test_long_line();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
